// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
//
// Instruction fetch front end: issues word-aligned requests to instruction
// memory, buffers returned words with their PCs in a 2-entry FIFO and hands
// them to decode through a valid/ready handshake. Redirects flush the FIFO and
// retarget fetching; a request already in flight at redirect time is allowed
// to complete and its data is thrown away.
//
// Parameters
//   RESET_PC       first fetch address after reset (word aligned)
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-low reset
//   imem_req_o     memory request (level, held until acknowledged)
//   imem_addr_o    memory request address (word aligned)
//   imem_ack_i     memory completes the current request this cycle
//   imem_data_i    instruction word, valid with imem_ack_i
//   redirect_i     branch/jump redirect pulse
//   redirect_pc_i  redirect target (low two bits ignored)
//   instr_valid_o  head FIFO entry is valid
//   instr_ready_i  decode accepts the head entry
//   instr_o        head instruction word
//   pc_o           address of instr_o
//   pc_plus4_o     pc_o + 4 (wraps modulo 2^32)
// -----------------------------------------------------------------------------
module instr_fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    // FETCH: request active (or about to start), HOLD: FIFO full, no request,
    // DROP: a request issued before a redirect is still outstanding.
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;

    logic [1:0]  state_reg,      state_next;
    logic        req_reg,        req_next;
    logic [31:0] fetch_pc_reg,   fetch_pc_next;
    logic [31:0] pending_pc_reg, pending_pc_next;
    logic [1:0]  count_reg,      count_next;
    logic        rd_ptr_reg,     rd_ptr_next;
    logic        wr_ptr_reg,     wr_ptr_next;

    logic        ack_eff;
    logic        pop;
    logic        push;
    logic [31:0] redirect_target;

    logic [31:0] slot_pc   [2];
    logic [31:0] slot_instr[2];

    // An ack with no request outstanding is meaningless and is ignored.
    assign ack_eff         = imem_ack_i & req_reg;
    assign pop             = instr_valid_o & instr_ready_i;
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;
    // Data is kept only for a request that belongs to the current stream:
    // acks in DROP, or coinciding with a redirect, are discarded.
    assign push            = ack_eff & (state_reg == ST_FETCH) & ~redirect_i;

    always_comb begin
        state_next      = state_reg;
        req_next        = req_reg;
        fetch_pc_next   = fetch_pc_reg;
        pending_pc_next = pending_pc_reg;
        count_next      = count_reg;
        rd_ptr_next     = rd_ptr_reg;
        wr_ptr_next     = wr_ptr_reg;

        // FIFO bookkeeping. A handshake in a redirect cycle still counts as
        // consumed by decode; the flush simply discards whatever remains.
        if (redirect_i) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (push) wr_ptr_next = ~wr_ptr_reg;
            if (pop)  rd_ptr_next = ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end

        case (state_reg)
            ST_FETCH: begin
                if (redirect_i) begin
                    if (req_reg && !ack_eff) begin
                        // Old address must stay on the bus until the memory
                        // answers, so the new target waits in pending_pc.
                        state_next      = ST_DROP;
                        pending_pc_next = redirect_target;
                        req_next        = 1'b1;
                    end else begin
                        fetch_pc_next = redirect_target;
                        req_next      = 1'b1;
                    end
                end else if (ack_eff) begin
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    // Occupancy 2 leaves no room for another outstanding word.
                    if (count_next == 2'd2) begin
                        state_next = ST_HOLD;
                        req_next   = 1'b0;
                    end else begin
                        req_next = 1'b1;
                    end
                end else begin
                    // Covers the first cycle after reset, where no request is
                    // active yet.
                    req_next = 1'b1;
                end
            end

            ST_HOLD: begin
                if (redirect_i) begin
                    fetch_pc_next = redirect_target;
                    state_next    = ST_FETCH;
                    req_next      = 1'b1;
                end else if (pop) begin
                    state_next = ST_FETCH;
                    req_next   = 1'b1;
                end
            end

            ST_DROP: begin
                if (redirect_i) begin
                    pending_pc_next = redirect_target;
                end
                if (ack_eff) begin
                    // Latest target wins, including one arriving with the ack.
                    fetch_pc_next = pending_pc_next;
                    state_next    = ST_FETCH;
                    req_next      = 1'b1;
                end
            end

            default: begin
                state_next = ST_FETCH;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= ST_FETCH;
            req_reg        <= 1'b0;
            fetch_pc_reg   <= RESET_PC;
            pending_pc_reg <= RESET_PC;
            count_reg      <= 2'd0;
            rd_ptr_reg     <= 1'b0;
            wr_ptr_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_reg        <= req_next;
            fetch_pc_reg   <= fetch_pc_next;
            pending_pc_reg <= pending_pc_next;
            count_reg      <= count_next;
            rd_ptr_reg     <= rd_ptr_next;
            wr_ptr_reg     <= wr_ptr_next;
        end
    end

    // Storage slots are reset so the head presents pc 0 / instr 0 after reset.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            localparam logic SLOT = 1'(gi);
            logic [31:0] pc_reg;
            logic [31:0] instr_reg;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    pc_reg    <= 32'd0;
                    instr_reg <= 32'd0;
                end else if (push && (wr_ptr_reg == SLOT)) begin
                    pc_reg    <= fetch_pc_reg;
                    instr_reg <= imem_data_i;
                end
            end

            assign slot_pc[gi]    = pc_reg;
            assign slot_instr[gi] = instr_reg;
        end
    endgenerate

    assign imem_req_o    = req_reg;
    assign imem_addr_o   = fetch_pc_reg;
    assign instr_valid_o = (count_reg != 2'd0);
    assign instr_o       = slot_instr[rd_ptr_reg];
    assign pc_o          = slot_pc[rd_ptr_reg];
    assign pc_plus4_o    = slot_pc[rd_ptr_reg] + 32'd4;

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_buffer
//
// Directed bench for instr_fetch_buffer. The stimulus process drives the
// memory and decode sides and pushes hand-computed expectations (request
// addresses at ack time, {pc, instr} at decode handshake) into queues; a
// monitor on the falling edge pops and compares whenever the DUT completes a
// memory handshake or presents an accepted instruction. Direct checks cover
// reset values, stall/hold behaviour and redirect timing.
// -----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    out_t        exp_out_q[$];
    logic [31:0] exp_addr_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_buffer #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    task automatic ack_word(input logic [31:0] addr, input logic [31:0] data, input bit keep);
        imem_ack_i  = 1'b1;
        imem_data_i = data;
        exp_addr_q.push_back(addr);
        if (keep) exp_out_q.push_back('{pc: addr, instr: data});
    endtask

    // Monitor: memory handshakes and decode handshakes, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            if (imem_req_o && imem_ack_i) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_ack: addr %h with no expected request", imem_addr_o);
                end else begin
                    logic [31:0] a;
                    a = exp_addr_q.pop_front();
                    $display("ack  addr=%h data=%h", imem_addr_o, imem_data_i);
                    check("req_addr", imem_addr_o, a);
                end
            end
            if (instr_valid_o && instr_ready_i) begin
                if (exp_out_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_pop: pc %h instr %h with nothing expected", pc_o, instr_o);
                end else begin
                    out_t e;
                    logic [31:0] e_pc4;
                    e     = exp_out_q.pop_front();
                    e_pc4 = e.pc + 32'd4;
                    $display("pop  pc=%h instr=%h pc4=%h", pc_o, instr_o, pc_plus4_o);
                    check("pop_instr", instr_o, e.instr);
                    check("pop_pc", pc_o, e.pc);
                    check("pop_pc4", pc_plus4_o, e_pc4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'd0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        instr_ready_i = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_req",   32'(imem_req_o),    32'd0);
        check("rst_instr", instr_o,            32'd0);
        check("rst_pc",    pc_o,               32'd0);
        check("rst_pc4",   pc_plus4_o,         32'd4);
        check("rst_addr",  imem_addr_o,        32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        check("first_req",  32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o,     32'd0);

        // Streaming, ack one cycle after each request, decode always ready.
        instr_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] a;
            logic [31:0] d;
            a = 32'(k) * 32'd4;
            d = 32'h1111_0000 * 32'(k + 1) + a;
            tick();
            ack_word(a, d, 1'b1);
            tick();
            imem_ack_i = 1'b0;
            check("stream_valid", 32'(instr_valid_o), 32'd1);
            check("stream_pc",    pc_o,               a);
        end
        tick();
        tick();

        // Backpressure: two acks fill the FIFO and stop requests.
        instr_ready_i = 1'b0;
        do_reset();
        ack_word(32'h0, 32'hB000_0000, 1'b1);
        tick();
        ack_word(32'h4, 32'hB000_0004, 1'b1);
        tick();
        imem_ack_i = 1'b0;
        check("hold_req",   32'(imem_req_o),    32'd0);
        check("hold_valid", 32'(instr_valid_o), 32'd1);
        check("hold_addr",  imem_addr_o,        32'h8);
        // Ack with no request outstanding must not disturb anything.
        imem_ack_i  = 1'b1;
        imem_data_i = 32'hBAD0_BAD0;
        tick();
        imem_ack_i = 1'b0;
        tick();
        check("stall_req",   32'(imem_req_o), 32'd0);
        check("stall_pc",    pc_o,            32'h0);
        check("stall_instr", instr_o,         32'hB000_0000);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check("resume_req",  32'(imem_req_o), 32'd1);
        check("resume_addr", imem_addr_o,     32'h8);
        check("resume_pc",   pc_o,            32'h4);
        ack_word(32'h8, 32'hB000_0008, 1'b1);
        tick();
        imem_ack_i = 1'b0;
        check("hold2_req", 32'(imem_req_o), 32'd0);
        instr_ready_i = 1'b1;
        tick();
        tick();
        tick();

        // Redirect coincident with ack: acked word is discarded.
        do_reset();
        ack_word(32'h0, 32'hDEAD_0000, 1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0010;
        tick();
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
        check("coinc_valid", 32'(instr_valid_o), 32'd0);
        check("coinc_addr",  imem_addr_o,        32'h10);
        check("coinc_req",   32'(imem_req_o),    32'd1);
        tick();
        check("coinc_valid2", 32'(instr_valid_o), 32'd0);

        // Redirect with request at 0x10 pending, ack three cycles later.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick();
        redirect_i = 1'b0;
        check("drop_addr_held", imem_addr_o,     32'h10);
        check("drop_req_held",  32'(imem_req_o), 32'd1);
        tick();
        check("drop_addr_held2", imem_addr_o,        32'h10);
        check("drop_valid",      32'(instr_valid_o), 32'd0);
        tick();
        check("drop_addr_held3", imem_addr_o, 32'h10);
        ack_word(32'h10, 32'hBAD0_0010, 1'b0);
        tick();
        imem_ack_i = 1'b0;
        check("drop_new_addr",  imem_addr_o,        32'h100);
        check("drop_new_valid", 32'(instr_valid_o), 32'd0);
        check("drop_new_req",   32'(imem_req_o),    32'd1);
        ack_word(32'h100, 32'hC000_0100, 1'b1);
        tick();
        imem_ack_i = 1'b0;
        check("target_valid", 32'(instr_valid_o), 32'd1);
        check("target_pc",    pc_o,               32'h100);

        // Two redirects while dropping: the later target wins. The first one
        // coincides with a decode handshake of the 0x100 entry.
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick();
        check("drop2_addr",  imem_addr_o,        32'h104);
        check("drop2_valid", 32'(instr_valid_o), 32'd0);
        redirect_pc_i = 32'h0000_0407;
        tick();
        redirect_i = 1'b0;
        ack_word(32'h104, 32'hBAD0_0104, 1'b0);
        tick();
        imem_ack_i = 1'b0;
        check("drop2_new_addr", imem_addr_o,        32'h404);
        check("drop2_new_valid", 32'(instr_valid_o), 32'd0);

        // Wrap at the top of the address space.
        instr_ready_i = 1'b0;
        ack_word(32'h404, 32'hBAD0_0404, 1'b0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        ack_word(32'hFFFF_FFFC, 32'h1234_5678, 1'b1);
        tick();
        imem_ack_i = 1'b0;
        check("wrap_next_addr", imem_addr_o,        32'h0);
        check("wrap_pc",        pc_o,               32'hFFFF_FFFC);
        check("wrap_pc4",       pc_plus4_o,         32'h0);
        check("wrap_valid",     32'(instr_valid_o), 32'd1);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;

        // Fill to two entries, consume one, then reset mid-request.
        ack_word(32'h0, 32'hE000_0000, 1'b1);
        tick();
        ack_word(32'h4, 32'hE000_0004, 1'b0);
        tick();
        imem_ack_i = 1'b0;
        check("full_req", 32'(imem_req_o), 32'd0);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check("mid_req",  32'(imem_req_o), 32'd1);
        check("mid_addr", imem_addr_o,     32'h8);
        rst_i = 1'b0;
        #2;
        check("async_valid", 32'(instr_valid_o), 32'd0);
        check("async_req",   32'(imem_req_o),    32'd0);
        check("async_instr", instr_o,            32'd0);
        check("async_pc",    pc_o,               32'd0);
        check("async_pc4",   pc_plus4_o,         32'd4);
        check("async_addr",  imem_addr_o,        32'd0);
        tick();
        rst_i = 1'b1;
        tick();
        check("refetch_req",   32'(imem_req_o),    32'd1);
        check("refetch_addr",  imem_addr_o,        32'd0);
        check("refetch_valid", 32'(instr_valid_o), 32'd0);
        ack_word(32'h0, 32'hF000_0000, 1'b1);
        instr_ready_i = 1'b1;
        tick();
        imem_ack_i = 1'b0;
        tick();
        tick();

        check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        check("out_queue_drained",  32'(exp_out_q.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
